// File: rtl/cv32e40p_register_file_sb.sv
// Flip-flop register file with configurable read/write ports, optional write-to-read
// bypass and a per-register busy scoreboard for long-latency writebacks.
module cv32e40p_register_file_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 3,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_READ-1:0]              rbusy_o,
    input  logic [NUM_WRITE-1:0]             we_i,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_WRITE-1:0]             wclr_i,
    input  logic                             rsv_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    output logic                             rsv_ready_o,
    output logic [ADDR_WIDTH:0]              pending_cnt_o
);

    localparam int NUM_WORDS = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]  busy_q, busy_d;
    logic [NUM_WORDS-1:0]  clr_vec;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d, dec;
    logic [ADDR_WIDTH-1:0] wa [NUM_WRITE];
    logic [ADDR_WIDTH-1:0] ra [NUM_READ];
    logic                  rsv_zero, rsv_acc, inc;

    // Ascending port order makes the highest-indexed writer win on collisions.
    always_comb begin
        clr_vec = '0;
        for (int a = 0; a < NUM_WORDS; a++) begin
            mem_d[a] = mem_q[a];
        end
        for (int w = 0; w < NUM_WRITE; w++) begin
            wa[w] = waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
            if (we_i[w] && (ZERO_REG == 0 || wa[w] != '0)) begin
                mem_d[wa[w]] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
                if (wclr_i[w]) begin
                    clr_vec[wa[w]] = 1'b1;
                end
            end
        end
    end

    assign rsv_zero    = (ZERO_REG != 0) && (rsv_addr_i == '0);
    assign rsv_ready_o = !rsv_i || !busy_q[rsv_addr_i] || clr_vec[rsv_addr_i];
    assign rsv_acc     = rsv_i && rsv_ready_o && !rsv_zero;

    // A reservation landing on a register being cleared keeps it busy (WAW handoff),
    // so that register must not be counted as released.
    always_comb begin
        busy_d = busy_q & ~clr_vec;
        if (rsv_acc) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
        dec = '0;
        for (int a = 0; a < NUM_WORDS; a++) begin
            if (busy_q[a] && clr_vec[a] && !(rsv_acc && rsv_addr_i == ADDR_WIDTH'(a))) begin
                dec = dec + CNT_ONE;
            end
        end
        inc   = rsv_acc && !busy_q[rsv_addr_i];
        cnt_d = cnt_q + (inc ? CNT_ONE : '0) - dec;
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            ra[r] = raddr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
            rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra[r]];
            rbusy_o[r] = busy_q[ra[r]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WRITE; w++) begin
                    if (we_i[w] && wa[w] == ra[r]) begin
                        rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (clr_vec[ra[r]] && !(rsv_acc && rsv_addr_i == ra[r])) begin
                    rbusy_o[r] = 1'b0;
                end
            end
            if (ZERO_REG != 0 && ra[r] == '0) begin
                rdata_o[r*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy_o[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_WORDS; a++) begin
                mem_q[a] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int a = 0; a < NUM_WORDS; a++) begin
                mem_q[a] <= mem_d[a];
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt_o = cnt_q;

endmodule

// File: doc/cv32e40p_register_file_sb.md
Name: cv32e40p_register_file_sb

Overview:
- Parametrised flip-flop register file, successor to the latch-based integer/FP register file.
- Configurable numbers of read and write ports.
- Optional same-cycle write-to-read bypass.
- Per-register scoreboard (busy bits plus outstanding-write counter) so the decoder can stall on operands whose long-latency producer (divider, FPU, LSU) has not yet written back.
- Sits between ID stage operand fetch and the WB/LSU/APU writeback paths.

Parameters:
ADDR_WIDTH, 5, register address width; NUM_WORDS = 2**ADDR_WIDTH
DATA_WIDTH, 32, register width in bits
NUM_READ, 3, number of read ports (>=1)
NUM_WRITE, 2, number of write ports (>=1)
ZERO_REG, 1, 1: register 0 reads 0, writes and reservations to it are ignored
BYPASS, 1, 1: same-cycle write data and scoreboard clears are forwarded to read ports

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
raddr_i  in  NUM_READ*ADDR_WIDTH  read addresses, port r at slice r
rdata_o  out  NUM_READ*DATA_WIDTH  read data
rbusy_o  out  NUM_READ  addressed register has a pending reserved write
we_i  in  NUM_WRITE  write enables
waddr_i  in  NUM_WRITE*ADDR_WIDTH  write addresses
wdata_i  in  NUM_WRITE*DATA_WIDTH  write data
wclr_i  in  NUM_WRITE  write also clears the target's busy bit (valid only with we_i)
rsv_i  in  1  reserve a register for a future write
rsv_addr_i  in  ADDR_WIDTH  register to reserve
rsv_ready_o  out  1  reservation accepted this cycle
pending_cnt_o  out  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset (rst=1 at posedge clk): all registers 0, all busy bits 0, pending_cnt_o=0. A reset during pending reservations discards them; same-cycle writes and reservations are dropped.
- Writes:
  - Registered; data is visible on the read path the cycle after the write.
  - Same-address collision between write ports: highest-indexed port wins.
  - ZERO_REG=1: writes to address 0 have no effect; address 0 always reads 0 and busy 0.
- Reads:
  - Combinational from the array.
  - BYPASS=1: if any we_i[w] targets raddr this cycle, rdata returns that port's wdata (highest index wins). Address 0 excluded when ZERO_REG=1.
  - BYPASS=0: old value is returned until the next cycle.
- Scoreboard set:
  - rsv_ready_o = !rsv_i | !busy[rsv_addr_i] | same-cycle clear of rsv_addr_i.
  - When rsv_i & rsv_ready_o: busy[rsv_addr_i] <= 1 next cycle.
  - Reserving an already-busy register without a same-cycle clear is refused (rsv_ready_o=0, no state change); the requester holds rsv_i.
- Scoreboard clear: we_i[w] & wclr_i[w] clears busy[waddr] next cycle. wclr_i without we_i is ignored.
- Simultaneous reserve and clear of the same address: the reservation wins, busy stays 1 (write-after-write handoff); the write data is still committed.
- rbusy_o[r] = busy[raddr_r]. With BYPASS=1 it is masked to 0 by a same-cycle clearing write to that address, unless a same-cycle reservation also targets it.
- pending_cnt_o:
  - Registered popcount of busy bits, maintained incrementally: +1 per accepted reservation of a non-busy register, -1 per distinct register cleared.
  - Never wraps; max value NUM_WORDS-ZERO_REG.
- Clearing a non-busy register: no effect on busy or counter.

Test Plan:
- Reset then read all addresses -> rdata_o=0, rbusy_o=0, pending_cnt_o=0; write r5=0xDEADBEEF via port 0 -> next cycle port 1 reads 0xDEADBEEF.
- Both write ports to r7 (0x11111111, 0x22222222) same cycle -> r7=0x22222222. Write r0=0xFFFFFFFF -> r0 still reads 0.
- BYPASS=1: write r3=0xA5A5A5A5 with raddr_a=3 same cycle -> rdata_o port 0 = 0xA5A5A5A5 same cycle. BYPASS=0 -> old value 0, then 0xA5A5A5A5 next cycle.
- Reserve r10 -> next cycle rbusy=1, pending_cnt_o=1. Second reserve r10 -> rsv_ready_o=0. Write r10 with wclr -> busy clears next cycle, pending_cnt_o=0. With BYPASS=1, rbusy masked to 0 in the write cycle.
- Same cycle: reserve r12 (busy) and clearing write r12=0x5 -> rsv_ready_o=1, busy stays 1, r12=0x5, pending_cnt_o unchanged at 1.
- Reserve r1, r2, r3 on consecutive cycles, assert rst on the fourth -> all busy=0, pending_cnt_o=0, registers 0 after reset.
